// File: rtl/aes_dec_pkg.sv
// Shared AES-128 inverse-cipher constants, types and byte-level helpers
// used by decrypt_rounds_iter and inv_mix_columns.
package aes_dec_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = (NR + 1) * 128;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} dec_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (9, 0xB, 0xD, 0xE) via its binary expansion.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // Byte i lives at [127-8i -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// Combinational AES InvMixColumns over a full 128-bit state, one
// column network per 32-bit column.
module inv_mix_columns
    import aes_dec_pkg::*;
(
    input  logic [127:0] state,
    output logic [127:0] mixed
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = state[127 - 32*gi -: 8];
            assign a1 = state[119 - 32*gi -: 8];
            assign a2 = state[111 - 32*gi -: 8];
            assign a3 = state[103 - 32*gi -: 8];
            assign mixed[127 - 32*gi -: 32] = {
                gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)
            };
        end
    endgenerate

endmodule

// File: rtl/decrypt_rounds_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Define DEC_STATE_TAP_EN to expose dbg_state/dbg_round.
module decrypt_rounds_iter
    import aes_dec_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   expanded_key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       ciphertext,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DEC_STATE_TAP_EN
    output logic [127:0]       dbg_state,
    output logic [3:0]         dbg_round,
`endif
    output logic [127:0]       plaintext
);

    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    // Padded to 16 entries so every 4-bit round index selects something defined.
    logic [127:0] rk [16];
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rk
            if (gi <= NR) begin : g_used
                assign rk[gi] = expanded_key[KEY_W - 1 - 128*gi -: 128];
            end else begin : g_pad
                assign rk[gi] = '0;
            end
        end
    endgenerate

    dec_state_t   state_reg, state_next;
    logic [3:0]   rnd_reg, rnd_next;
    logic [127:0] data_reg, data_next;
    logic [127:0] plaintext_reg, plaintext_next;
    logic         out_valid_reg, out_valid_next;
    logic [127:0] round_out, mixed;

    assign round_out = inv_sub_bytes(inv_shift_rows(data_reg)) ^ rk[rnd_reg];

    inv_mix_columns u_inv_mix_columns (
        .state (round_out),
        .mixed (mixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rnd_reg       <= '0;
            data_reg      <= '0;
            plaintext_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rnd_reg       <= rnd_next;
            data_reg      <= data_next;
            plaintext_reg <= plaintext_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rnd_next       = rnd_reg;
        data_next      = data_reg;
        plaintext_next = plaintext_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = ciphertext ^ rk[NR];
                    rnd_next   = LAST_RND;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (rnd_reg > LAST_RND) begin
                    // Unreachable round index: recover to idle rather than decrypt garbage.
                    rnd_next   = '0;
                    state_next = IDLE;
                end else if (rnd_reg != 4'd0) begin
                    data_next = mixed;
                    rnd_next  = rnd_reg - 4'd1;
                end else begin
                    plaintext_next = round_out;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign plaintext = plaintext_reg;

`ifdef DEC_STATE_TAP_EN
    assign dbg_state = data_reg;
    assign dbg_round = (state_reg == ROUND) ? rnd_reg : 4'hF;
`endif

endmodule

// File: tb/tb_decrypt_rounds_iter.sv
// Directed FIPS-197 vectors against decrypt_rounds_iter with backpressure,
// back-to-back and mid-run reset; dbg taps checked when DEC_STATE_TAP_EN is set.
module tb_decrypt_rounds_iter;

    localparam logic [1407:0] KEY_B = {
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [1407:0] KEY_C = {
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1407:0] expanded_key;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  ciphertext;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  plaintext;
`ifdef DEC_STATE_TAP_EN
    logic [127:0]  dbg_state;
    logic [3:0]    dbg_round;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decrypt_rounds_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .expanded_key (expanded_key),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ciphertext   (ciphertext),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
`ifdef DEC_STATE_TAP_EN
        .dbg_state    (dbg_state),
        .dbg_round    (dbg_round),
`endif
        .plaintext    (plaintext)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp)
            $display("check %0d %s ok value=%h", checks, tag, got);
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        expanded_key = '0;
        in_valid     = 1'b0;
        ciphertext   = '0;
        out_ready    = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_plaintext", plaintext, 128'd0);
`ifdef DEC_STATE_TAP_EN
        chk("reset_dbg_state", dbg_state, 128'd0);
        chk("reset_dbg_round", 128'(dbg_round), 128'hF);
`endif
        rst_n = 1'b1;
        tick();

        // FIPS-197 B, latency and dbg round sequence
        expanded_key = KEY_B;
        ciphertext   = CT_B;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("b_in_ready_busy", 128'(in_ready), 128'd0);
`ifdef DEC_STATE_TAP_EN
        chk("b_dbg_state_accept", dbg_state, CT_B ^ RK10_B);
        chk("b_dbg_round_9", 128'(dbg_round), 128'd9);
`endif
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("b_out_valid_early", 128'(out_valid), 128'd0);
`ifdef DEC_STATE_TAP_EN
            chk("b_dbg_round_seq", 128'(dbg_round), 128'(9 - i));
`endif
        end
        tick();
        chk("b_out_valid", 128'(out_valid), 128'd1);
        chk("b_plaintext", plaintext, PT_B);
`ifdef DEC_STATE_TAP_EN
        chk("b_dbg_round_done", 128'(dbg_round), 128'hF);
`endif
        tick();
        chk("b_out_valid_clear", 128'(out_valid), 128'd0);
        chk("b_in_ready_back", 128'(in_ready), 128'd1);

        // FIPS-197 C.1 under 20 cycles of backpressure
        expanded_key = KEY_C;
        ciphertext   = CT_C;
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        tick();
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        chk("bp_plaintext", plaintext, PT_C);
        in_valid   = 1'b1;
        ciphertext = CT_B;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_pt", plaintext, PT_C);
            chk("bp_no_accept", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);
        tick();
        chk("bp_idle_ready", 128'(in_ready), 128'd1);

        // Back-to-back B then C.1 with in_valid held high
        expanded_key = KEY_B;
        ciphertext   = CT_B;
        in_valid     = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("b2b_in_ready_busy", 128'(in_ready), 128'd0);
        end
        chk("b2b_first_valid", 128'(out_valid), 128'd1);
        chk("b2b_first_pt", plaintext, PT_B);
        tick();
        chk("b2b_gap_ready", 128'(in_ready), 128'd1);
        chk("b2b_gap_valid", 128'(out_valid), 128'd0);
        expanded_key = KEY_C;
        ciphertext   = CT_C;
        tick();
        chk("b2b_second_accept", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("b2b_second_early", 128'(out_valid), 128'd0);
        end
        tick();
        chk("b2b_second_valid", 128'(out_valid), 128'd1);
        chk("b2b_second_pt", plaintext, PT_C);
        tick();
        chk("b2b_end_valid", 128'(out_valid), 128'd0);

        // Reset at round 5 of B, then clean C.1
        expanded_key = KEY_B;
        ciphertext   = CT_B;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_plaintext", plaintext, 128'd0);
`ifdef DEC_STATE_TAP_EN
        chk("mid_rst_dbg_state", dbg_state, 128'd0);
        chk("mid_rst_dbg_round", 128'(dbg_round), 128'hF);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_stale", 128'(out_valid), 128'd0);
        expanded_key = KEY_C;
        ciphertext   = CT_C;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("post_rst_early", 128'(out_valid), 128'd0);
        end
        tick();
        chk("post_rst_valid", 128'(out_valid), 128'd1);
        chk("post_rst_pt", plaintext, PT_C);
        tick();
        chk("post_rst_end", 128'(out_valid), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
